// File: rtl/mic_level_meter.sv
// Windowed peak-amplitude meter: tracks the max microphone sample over WINDOW samples and
// publishes a 0-15 level. Optional hold-and-decay display level under `MIC_LEVEL_DECAY_EN.
module mic_level_meter #(
  parameter int unsigned WINDOW        = 2000,
  parameter int unsigned BASELINE      = 2048,
  parameter int unsigned DECAY_WINDOWS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  output logic [11:0] peak_raw,
  output logic [3:0]  level,
  output logic [3:0]  level_disp,
  output logic        clip,
  output logic        level_valid,
  output logic [1:0]  fsm_state
);

  // Handshake: sample_valid has no ready; every strobed sample is accepted in its cycle.
  // level_valid is a single-cycle pulse; peak_raw/level/level_disp/clip hold until the next one.

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_QUANT   = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(WINDOW - 1);
  localparam logic [12:0] BASE     = 13'(BASELINE);

  state_t      state_q, state_d;
  logic [11:0] acc_max;
  logic        acc_clip;
  logic [15:0] cnt;
  logic [11:0] win_max;
  logic        win_clip;
  logic [3:0]  lvl_q;

  logic        sample_clip;
  logic [11:0] merged_max;
  logic        win_close;
  logic        publish;
  logic [12:0] win_ext;
  logic [12:0] diff;
  logic [3:0]  lvl;
  logic [3:0]  disp_d;

  always_comb begin
    sample_clip = (mic_in == 12'd0) || (mic_in == 12'hFFF);
    merged_max  = (mic_in > acc_max) ? mic_in : acc_max;
    win_close   = sample_valid && (cnt == LAST_IDX);
    publish     = (state_q == ST_PUBLISH);
  end

  // Accumulator hands the finished window to win_* and restarts in the same cycle,
  // so back-to-back samples are never dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_max  <= 12'd0;
      acc_clip <= 1'b0;
      cnt      <= 16'd0;
      win_max  <= 12'd0;
      win_clip <= 1'b0;
    end else if (sample_valid) begin
      if (win_close) begin
        win_max  <= merged_max;
        win_clip <= acc_clip | sample_clip;
        acc_max  <= 12'd0;
        acc_clip <= 1'b0;
        cnt      <= 16'd0;
      end else begin
        acc_max  <= merged_max;
        acc_clip <= acc_clip | sample_clip;
        cnt      <= cnt + 16'd1;
      end
    end
  end

  // Excursion above mid-scale, clamped to 11 bits; level is its top nibble.
  always_comb begin
    win_ext = {1'b0, win_max};
    diff    = (win_ext > BASE) ? (win_ext - BASE) : 13'd0;
    lvl     = (diff > 13'd2047) ? 4'hF : diff[10:7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_ACC;
    case (state_q)
      ST_ACC:     state_d = ST_ACC;
      ST_QUANT:   state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_ACC;
      default:    state_d = ST_ACC;
    endcase
    // With WINDOW=2 and continuous samples a close can coincide with PUBLISH.
    if (win_close) state_d = ST_QUANT;
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 4'd0;
    end else if (state_q == ST_QUANT) begin
      lvl_q <= lvl;
    end
  end

`ifdef MIC_LEVEL_DECAY_EN
  localparam logic [7:0] DECAY_LAST = 8'(DECAY_WINDOWS - 1);

  logic [7:0] decay_cnt;
  logic [7:0] decay_d;

  // A lower level never pulls the display down directly; it only steps down once
  // per DECAY_WINDOWS publishes, and stays >= the current level because it only
  // decrements when the current level is strictly below it.
  always_comb begin
    disp_d  = level_disp;
    decay_d = decay_cnt;
    if (lvl_q >= level_disp) begin
      disp_d  = lvl_q;
      decay_d = 8'd0;
    end else if (decay_cnt == DECAY_LAST) begin
      disp_d  = level_disp - 4'd1;
      decay_d = 8'd0;
    end else begin
      decay_d = decay_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decay_cnt <= 8'd0;
    end else if (publish) begin
      decay_cnt <= decay_d;
    end
  end
`else
  always_comb begin
    disp_d = lvl_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_raw    <= 12'd0;
      level       <= 4'd0;
      level_disp  <= 4'd0;
      clip        <= 1'b0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= publish;
      if (publish) begin
        peak_raw   <= win_max;
        level      <= lvl_q;
        level_disp <= disp_d;
        clip       <= win_clip;
      end
    end
  end

endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboard bench for mic_level_meter (WINDOW=4): a window-level model pushes expected
// publishes into exp_q; a negedge monitor pops and compares on every level_valid.
module tb_mic_level_meter;

  localparam int WIN   = 4;
  localparam int BASEL = 2048;
  localparam int DECW  = 2;
  localparam int EW    = 53;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [11:0] peak_raw;
  logic [3:0]  level;
  logic [3:0]  level_disp;
  logic        clip;
  logic        level_valid;
  logic [1:0]  fsm_state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // {publish cycle[52:21], peak[20:9], level[8:5], disp[4:1], clip[0]}
  logic [EW-1:0] exp_q[$];

  int cur_q[$];
  int hold_peak = 0;
  int hold_k    = 0;
  int model_disp = 0;

  mic_level_meter #(
    .WINDOW(WIN),
    .BASELINE(BASEL),
    .DECAY_WINDOWS(DECW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .mic_in(mic_in),
    .peak_raw(peak_raw),
    .level(level),
    .level_disp(level_disp),
    .clip(clip),
    .level_valid(level_valid),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint actual, input longint expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // reference model: whole-window view
  task automatic model_sample(input int s, input int pub_cyc);
    int mx, cl, amp, lv;
    logic [EW-1:0] e;
    cur_q.push_back(s);
    if (cur_q.size() == WIN) begin
      mx = 0;
      cl = 0;
      foreach (cur_q[i]) begin
        if (cur_q[i] > mx) mx = cur_q[i];
        if (cur_q[i] == 0 || cur_q[i] == 4095) cl = 1;
      end
      amp = (mx > BASEL) ? mx - BASEL : 0;
      if (amp > 2047) amp = 2047;
      lv = amp / 128;
`ifdef MIC_LEVEL_DECAY_EN
      if (lv >= model_disp) begin
        hold_peak = lv;
        hold_k    = 0;
        model_disp = lv;
      end else begin
        hold_k++;
        model_disp = hold_peak - hold_k / DECW;
        if (model_disp < lv) model_disp = lv;
      end
`else
      model_disp = lv;
`endif
      e = {32'(pub_cyc), 12'(mx), 4'(lv), 4'(model_disp), 1'(cl)};
      exp_q.push_back(e);
      cur_q.delete();
    end
  endtask

  task automatic model_reset();
    cur_q.delete();
    hold_peak  = 0;
    hold_k     = 0;
    model_disp = 0;
  endtask

  // driver tasks
  task automatic send(input logic [11:0] s);
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b1;
    mic_in = s;
    model_sample(int'(s), cyc + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
      mic_in = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic send_window(input int a, input int b, input int c, input int d, input int gap);
    send(12'(a)); idle($urandom_range(0, gap));
    send(12'(b)); idle($urandom_range(0, gap));
    send(12'(c)); idle($urandom_range(0, gap));
    send(12'(d)); idle($urandom_range(0, gap));
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      sample_valid = 1'b0;
      t++;
    end
    idle(3);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_peak_raw"}, peak_raw, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_level_disp"}, level_disp, 0);
    chk({tag, "_clip"}, clip, 0);
    chk({tag, "_level_valid"}, level_valid, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && level_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_level_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("publish_cycle", cyc, e[52:21]);
        chk("peak_raw", peak_raw, e[20:9]);
        chk("level", level, e[8:5]);
        chk("level_disp", level_disp, e[4:1]);
        chk("clip", clip, e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    mic_in = 12'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // quiet mid-scale, samples far apart
    for (int i = 0; i < WIN; i++) begin
      send(12'd2048);
      idle(4999);
    end
    drain("drain_slow");

    // directed windows: peak level, clamp-to-zero with clip, full-scale clip
    send_window(2048, 3000, 2100, 2048, 3);
    send_window(1000, 1500, 0, 2000, 3);
    send_window(100, 4095, 200, 300, 3);
    drain("drain_directed");

    // hold-and-decay: one loud window then quiet windows
    send_window(4095, 2048, 2048, 2048, 2);
    for (int w = 0; w < 4; w++) send_window(2048, 1900, 2048, 2000, 2);
    drain("drain_decay");

    // back-to-back samples, no gaps
    for (int i = 0; i < 3 * WIN; i++) send(12'($urandom_range(1, 4094)));
    idle(1);
    drain("drain_b2b");

    // randomized windows mixing edge codes and random gaps
    for (int i = 0; i < 20 * WIN; i++) begin
      case ($urandom_range(0, 7))
        0:       send(12'd0);
        1:       send(12'd4095);
        2:       send(12'(2048 + $urandom_range(0, 200)));
        default: send(12'($urandom_range(0, 4095)));
      endcase
      idle($urandom_range(0, 2));
    end
    drain("drain_random");

    // reset mid-window discards the partial window; sample during reset ignored
    send(12'd4000);
    send(12'd2500);
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b1;
    mic_in = 12'd4095;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
    chk_zero("midreset");
    send_window(2100, 2600, 2300, 2200, 2);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
